// File: rtl/bank_param.sv
// Parametrised simple-dual-port data bank with a byte-masked write source mux and a pipelined read.
// Read latency RDLAT (1 or 2); there is no backpressure, so reads and writes are accepted every cycle.
module bank_param #(
  parameter int W       = 64,
  parameter int A       = 10,
  parameter int NSRC    = 3,
  parameter int SW      = 2,
  parameter int RDLAT   = 1,
  parameter int RDW_NEW = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [A-1:0]      rd_addr,
  output logic [W-1:0]      rd_word,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [A-1:0]      wr_addr,
  input  logic [SW-1:0]     wr_sel,
  input  logic [NSRC*W-1:0] wr_words,
  input  logic [W/8-1:0]    wr_be,
  input  logic              err_clr,
  output logic              err_sel
);

  localparam int DEPTH = 1 << A;
  localparam int NB    = W / 8;

  if (W % 8 != 0) begin : g_chk_w
    $error("bank_param: W must be a multiple of 8");
  end
  if (RDLAT != 1 && RDLAT != 2) begin : g_chk_lat
    $error("bank_param: RDLAT must be 1 or 2");
  end
  if ((1 << SW) < NSRC) begin : g_chk_sw
    $error("bank_param: SW too narrow for NSRC");
  end

  logic [W-1:0] mem_q [DEPTH];

  logic [W-1:0] wr_word;
  logic [W-1:0] old_word;
  logic [W-1:0] merged_word;
  logic [W-1:0] rd_capture;
  logic         wr_legal;
  logic         wr_commit;
  logic         collide;

  logic         s1_vld_q;
  logic [W-1:0] s1_dat_q, s1_dat_d;
  logic         err_q, err_d;

  // Channels beyond NSRC are never selected, so an illegal select yields zero.
  always_comb begin
    wr_word = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (int'(wr_sel) == k) wr_word = wr_words[k*W +: W];
    end
  end

  assign wr_legal  = int'(wr_sel) < NSRC;
  assign wr_commit = wr_en && wr_legal;
  assign old_word  = mem_q[rd_addr];
  assign collide   = rd_en && wr_commit && (rd_addr == wr_addr);

  always_comb begin
    merged_word = old_word;
    for (int j = 0; j < NB; j++) begin
      if (wr_be[j]) merged_word[j*8 +: 8] = wr_word[j*8 +: 8];
    end
  end

  assign rd_capture = (RDW_NEW != 0 && collide) ? merged_word : old_word;
  assign s1_dat_d   = rd_en ? rd_capture : s1_dat_q;

  // Storage carries no reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int j = 0; j < NB; j++) begin
        if (wr_be[j]) mem_q[wr_addr][j*8 +: 8] <= wr_word[j*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
    end else begin
      s1_vld_q <= rd_en;
      s1_dat_q <= s1_dat_d;
    end
  end

  // A fresh illegal select outranks a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (wr_en && !wr_legal) err_d = 1'b1;
    else if (err_clr)       err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err_sel = err_q;

  if (RDLAT == 2) begin : g_lat2
    logic         s2_vld_q;
    logic [W-1:0] s2_dat_q, s2_dat_d;

    assign s2_dat_d = s1_vld_q ? s1_dat_q : s2_dat_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_vld_q <= 1'b0;
        s2_dat_q <= '0;
      end else begin
        s2_vld_q <= s1_vld_q;
        s2_dat_q <= s2_dat_d;
      end
    end

    assign rd_valid = s2_vld_q;
    assign rd_word  = s2_dat_q;
  end else begin : g_lat1
    assign rd_valid = s1_vld_q;
    assign rd_word  = s1_dat_q;
  end

endmodule
